// File: rtl/store_queue_pkg.sv
// Shared store-queue types and default sizing.
package Purple_Jade_pkg;

  localparam int unsigned SQ_ENTRY    = 8;
  localparam int unsigned WORD_SIZE_P = 16;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ALLOC     = 2'd1,
    RESOLVED  = 2'd2,
    COMMITTED = 2'd3
  } sq_state_e;

endpackage

// File: rtl/store_queue_fwd.sv
// Age-ordered store-to-load forwarding: youngest matching entry, tail-1 back to head.
module store_queue_fwd #(
  parameter  int unsigned SQ_ENTRY = 8,
  parameter  int unsigned ADDR_W   = 16,
  parameter  int unsigned DATA_W   = 16,
  localparam int unsigned IDX_W    = $clog2(SQ_ENTRY)
) (
  input  logic [SQ_ENTRY-1:0] valid_i,
  input  logic [ADDR_W-1:0]   addr_i [SQ_ENTRY],
  input  logic [DATA_W-1:0]   data_i [SQ_ENTRY],
  input  logic [IDX_W-1:0]    tail_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                hit_o,
  output logic [DATA_W-1:0]   data_o
);

  logic [IDX_W-1:0] idx;

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = SQ_ENTRY; k >= 1; k--) begin
      idx = tail_i - IDX_W'(k);
      if (valid_i[idx] && (addr_i[idx] == ld_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// Store queue: allocate at tail, resolve addresses, commit in order, drain committed stores to memory.
module store_queue #(
  parameter int unsigned SQ_ENTRY = Purple_Jade_pkg::SQ_ENTRY,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = Purple_Jade_pkg::WORD_SIZE_P,
  parameter int unsigned IDX_W    = $clog2(SQ_ENTRY)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              issue_v_i,
  input  logic [DATA_W-1:0] issue_data_i,
  output logic              issue_ready_o,
  output logic [IDX_W-1:0]  issue_idx_o,
  input  logic              exe_v_i,
  input  logic [IDX_W-1:0]  exe_idx_i,
  input  logic [ADDR_W-1:0] exe_addr_i,
  input  logic              commit_v_i,
  output logic              commit_ready_o,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              mem_v_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [IDX_W:0]    count_o
);
  import Purple_Jade_pkg::*;

  typedef struct packed {
    sq_state_e         state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            ent_q [SQ_ENTRY];
  logic [IDX_W-1:0]  head_q, cmt_q, tail_q;
  logic [IDX_W:0]    count_q, uncmt_q;
  logic              do_issue, do_commit, do_drain, exe_ok;
  logic [SQ_ENTRY-1:0] fwd_valid;
  logic [ADDR_W-1:0] fwd_addr [SQ_ENTRY];
  logic [DATA_W-1:0] fwd_data [SQ_ENTRY];

  assign issue_ready_o  = (count_q != (IDX_W+1)'(SQ_ENTRY)) && !flush_i;
  assign issue_idx_o    = tail_q;
  assign commit_ready_o = (ent_q[cmt_q].state == RESOLVED);
  assign mem_v_o        = (ent_q[head_q].state == COMMITTED);
  assign mem_addr_o     = ent_q[head_q].addr;
  assign mem_data_o     = ent_q[head_q].data;
  assign count_o        = count_q;

  assign do_issue  = issue_v_i && issue_ready_o;
  assign do_commit = commit_v_i && commit_ready_o;
  assign do_drain  = mem_v_o && mem_ready_i;
  assign exe_ok    = exe_v_i && !flush_i && (ent_q[exe_idx_i].state == ALLOC);

  always_comb begin
    for (int i = 0; i < SQ_ENTRY; i++) begin
      fwd_valid[i] = (ent_q[i].state == RESOLVED) || (ent_q[i].state == COMMITTED);
      fwd_addr[i]  = ent_q[i].addr;
      fwd_data[i]  = ent_q[i].data;
    end
  end

  store_queue_fwd #(
    .SQ_ENTRY (SQ_ENTRY),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_fwd (
    .valid_i   (fwd_valid),
    .addr_i    (fwd_addr),
    .data_i    (fwd_data),
    .tail_i    (tail_q),
    .ld_addr_i (ld_addr_i),
    .hit_o     (ld_hit_o),
    .data_o    (ld_data_o)
  );

  // The four entry actions touch disjoint states, so they never collide on one entry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SQ_ENTRY; i++) ent_q[i] <= '0;
      head_q  <= '0;
      cmt_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
      uncmt_q <= '0;
    end else begin
      if (exe_ok) begin
        ent_q[exe_idx_i].state <= RESOLVED;
        ent_q[exe_idx_i].addr  <= exe_addr_i;
      end
      if (do_commit) ent_q[cmt_q].state <= COMMITTED;
      if (flush_i) begin
        for (int i = 0; i < SQ_ENTRY; i++) begin
          if (((ent_q[i].state == ALLOC) || (ent_q[i].state == RESOLVED)) &&
              !(do_commit && (IDX_W'(i) == cmt_q)))
            ent_q[i].state <= FREE;
        end
      end
      if (do_drain) ent_q[head_q].state <= FREE;
      if (do_issue) begin
        ent_q[tail_q].state <= ALLOC;
        ent_q[tail_q].data  <= issue_data_i;
      end

      head_q <= head_q + IDX_W'(do_drain);
      cmt_q  <= cmt_q + IDX_W'(do_commit);
      if (flush_i) begin
        tail_q  <= cmt_q + IDX_W'(do_commit);
        uncmt_q <= '0;
        count_q <= count_q - uncmt_q + (IDX_W+1)'(do_commit) - (IDX_W+1)'(do_drain);
      end else begin
        tail_q  <= tail_q + IDX_W'(do_issue);
        uncmt_q <= uncmt_q + (IDX_W+1)'(do_issue) - (IDX_W+1)'(do_commit);
        count_q <= count_q + (IDX_W+1)'(do_issue) - (IDX_W+1)'(do_drain);
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed scenarios for store_queue with hand-computed expectations.
module tb_store_queue;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        issue_v_i;
  logic [15:0] issue_data_i;
  logic        issue_ready_o;
  logic [2:0]  issue_idx_o;
  logic        exe_v_i;
  logic [2:0]  exe_idx_i;
  logic [15:0] exe_addr_i;
  logic        commit_v_i;
  logic        commit_ready_o;
  logic        flush_i;
  logic [15:0] ld_addr_i;
  logic        ld_hit_o;
  logic [15:0] ld_data_o;
  logic        mem_v_o;
  logic        mem_ready_i;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_data_o;
  logic [3:0]  count_o;

  int tests_run = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  store_queue dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .issue_v_i      (issue_v_i),
    .issue_data_i   (issue_data_i),
    .issue_ready_o  (issue_ready_o),
    .issue_idx_o    (issue_idx_o),
    .exe_v_i        (exe_v_i),
    .exe_idx_i      (exe_idx_i),
    .exe_addr_i     (exe_addr_i),
    .commit_v_i     (commit_v_i),
    .commit_ready_o (commit_ready_o),
    .flush_i        (flush_i),
    .ld_addr_i      (ld_addr_i),
    .ld_hit_o       (ld_hit_o),
    .ld_data_o      (ld_data_o),
    .mem_v_o        (mem_v_o),
    .mem_ready_i    (mem_ready_i),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .count_o        (count_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; issue_v_i = 1'b0; issue_data_i = '0; exe_v_i = 1'b0;
    exe_idx_i = '0; exe_addr_i = '0; commit_v_i = 1'b0; flush_i = 1'b0;
    ld_addr_i = '0; mem_ready_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
  endtask

  task automatic issue(input logic [15:0] d);
    issue_v_i = 1'b1; issue_data_i = d;
    step();
    issue_v_i = 1'b0;
  endtask

  task automatic exe(input logic [2:0] idx, input logic [15:0] a);
    exe_v_i = 1'b1; exe_idx_i = idx; exe_addr_i = a;
    step();
    exe_v_i = 1'b0;
  endtask

  task automatic commit();
    commit_v_i = 1'b1;
    step();
    commit_v_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (issue_ready_o !== 1'b1) begin fails++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready_o); end
    tests_run++; if (issue_idx_o !== 3'd0) begin fails++; $display("FAIL reset_issue_idx: got %0d want 0", issue_idx_o); end
    tests_run++; if (commit_ready_o !== 1'b0) begin fails++; $display("FAIL reset_commit_ready: got %b want 0", commit_ready_o); end
    tests_run++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL reset_mem_v: got %b want 0", mem_v_o); end
    tests_run++; if (ld_hit_o !== 1'b0 || ld_data_o !== 16'h0) begin fails++; $display("FAIL reset_ld: got %b/%h want 0/0000", ld_hit_o, ld_data_o); end
    tests_run++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count_o); end
  endtask

  task automatic test_basic_drain();
    do_reset();
    issue(16'h1111);
    exe(3'd0, 16'h0040);
    tests_run++; if (commit_ready_o !== 1'b1) begin fails++; $display("FAIL basic_commit_ready: got %b want 1", commit_ready_o); end
    mem_ready_i = 1'b1;
    commit();
    tests_run++; if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h0040 || mem_data_o !== 16'h1111) begin
      fails++; $display("FAIL basic_mem: got v=%b a=%h d=%h want v=1 a=0040 d=1111", mem_v_o, mem_addr_o, mem_data_o); end
    step();
    tests_run++; if (count_o !== 4'd0 || mem_v_o !== 1'b0) begin fails++; $display("FAIL basic_empty: got cnt=%0d v=%b want 0/0", count_o, mem_v_o); end
    mem_ready_i = 1'b0;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) issue(16'h0100 + 16'(i));
    tests_run++; if (count_o !== 4'd8 || issue_ready_o !== 1'b0) begin fails++; $display("FAIL full_state: got cnt=%0d rdy=%b want 8/0", count_o, issue_ready_o); end
    issue(16'hDEAD);
    tests_run++; if (count_o !== 4'd8 || issue_idx_o !== 3'd0) begin fails++; $display("FAIL full_ignore: got cnt=%0d idx=%0d want 8/0", count_o, issue_idx_o); end
    exe(3'd0, 16'h0200);
    commit();
    // Issue and drain in the same cycle while full: only the drain happens.
    issue_v_i = 1'b1; issue_data_i = 16'hBEEF; mem_ready_i = 1'b1;
    step();
    issue_v_i = 1'b0; mem_ready_i = 1'b0;
    tests_run++; if (count_o !== 4'd7 || issue_ready_o !== 1'b1 || issue_idx_o !== 3'd0) begin
      fails++; $display("FAIL full_drain: got cnt=%0d rdy=%b idx=%0d want 7/1/0", count_o, issue_ready_o, issue_idx_o); end
    issue(16'h0108);
    tests_run++; if (count_o !== 4'd8 || issue_idx_o !== 3'd1) begin fails++; $display("FAIL full_wrap: got cnt=%0d idx=%0d want 8/1", count_o, issue_idx_o); end
  endtask

  task automatic test_forward();
    do_reset();
    issue(16'hAAAA);
    issue(16'hBBBB);
    issue(16'hCCCC);
    ld_addr_i = 16'h0010; #1;
    tests_run++; if (ld_hit_o !== 1'b0) begin fails++; $display("FAIL fwd_alloc_nohit: got %b want 0", ld_hit_o); end
    exe(3'd0, 16'h0010);
    tests_run++; if (ld_hit_o !== 1'b1 || ld_data_o !== 16'hAAAA) begin fails++; $display("FAIL fwd_one: got %b/%h want 1/aaaa", ld_hit_o, ld_data_o); end
    exe(3'd1, 16'h0010);
    exe(3'd2, 16'h0020);
    tests_run++; if (ld_hit_o !== 1'b1 || ld_data_o !== 16'hBBBB) begin fails++; $display("FAIL fwd_youngest: got %b/%h want 1/bbbb", ld_hit_o, ld_data_o); end
    ld_addr_i = 16'h0020; #1;
    tests_run++; if (ld_hit_o !== 1'b1 || ld_data_o !== 16'hCCCC) begin fails++; $display("FAIL fwd_c: got %b/%h want 1/cccc", ld_hit_o, ld_data_o); end
    ld_addr_i = 16'h0030; #1;
    tests_run++; if (ld_hit_o !== 1'b0 || ld_data_o !== 16'h0000) begin fails++; $display("FAIL fwd_miss: got %b/%h want 0/0000", ld_hit_o, ld_data_o); end
    ld_addr_i = 16'h0000;
  endtask

  task automatic test_flush_commit();
    do_reset();
    for (int i = 0; i < 5; i++) issue(16'h1000 + 16'(i));
    for (int i = 0; i < 5; i++) exe(3'(i), 16'h0080 + 16'(i));
    commit();
    commit();
    commit_v_i = 1'b1; flush_i = 1'b1; #1;
    tests_run++; if (issue_ready_o !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", issue_ready_o); end
    step();
    commit_v_i = 1'b0; flush_i = 1'b0;
    tests_run++; if (count_o !== 4'd3 || issue_idx_o !== 3'd3 || commit_ready_o !== 1'b0) begin
      fails++; $display("FAIL flush_state: got cnt=%0d tail=%0d crdy=%b want 3/3/0", count_o, issue_idx_o, commit_ready_o); end
    ld_addr_i = 16'h0082; #1;
    tests_run++; if (ld_hit_o !== 1'b1 || ld_data_o !== 16'h1002) begin fails++; $display("FAIL flush_kept: got %b/%h want 1/1002", ld_hit_o, ld_data_o); end
    exe(3'd4, 16'h0090);
    ld_addr_i = 16'h0090; #1;
    tests_run++; if (ld_hit_o !== 1'b0) begin fails++; $display("FAIL flush_exe_dropped: got %b want 0", ld_hit_o); end
    ld_addr_i = 16'h0084; #1;
    tests_run++; if (ld_hit_o !== 1'b0) begin fails++; $display("FAIL flush_gone: got %b want 0", ld_hit_o); end
    ld_addr_i = 16'h0000;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (mem_v_o !== 1'b1 || mem_data_o !== 16'h1000 + 16'(i)) begin
        fails++; $display("FAIL flush_drain%0d: got v=%b d=%h want 1/%h", i, mem_v_o, mem_data_o, 16'h1000 + 16'(i)); end
      step();
    end
    mem_ready_i = 1'b0;
    tests_run++; if (count_o !== 4'd0 || mem_v_o !== 1'b0) begin fails++; $display("FAIL flush_empty: got cnt=%0d v=%b want 0/0", count_o, mem_v_o); end
  endtask

  task automatic test_stall();
    do_reset();
    issue(16'h5A5A);
    exe(3'd0, 16'h0123);
    commit();
    for (int c = 0; c < 5; c++) begin
      tests_run++; if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h0123 || mem_data_o !== 16'h5A5A || count_o !== 4'd1) begin
        fails++; $display("FAIL stall_hold%0d: got v=%b a=%h d=%h c=%0d want 1/0123/5a5a/1", c, mem_v_o, mem_addr_o, mem_data_o, count_o); end
      step();
    end
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    tests_run++; if (mem_v_o !== 1'b0 || count_o !== 4'd0) begin fails++; $display("FAIL stall_pop: got v=%b c=%0d want 0/0", mem_v_o, count_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(16'h7777);
    exe(3'd0, 16'h0777);
    issue(16'h8888);
    commit();
    tests_run++; if (mem_v_o !== 1'b1) begin fails++; $display("FAIL areset_pre: got %b want 1", mem_v_o); end
    mem_ready_i = 1'b1;
    #2;
    reset_n_i = 1'b0;
    #1;
    tests_run++; if (mem_v_o !== 1'b0 || count_o !== 4'd0 || issue_ready_o !== 1'b1 || issue_idx_o !== 3'd0 ||
                     commit_ready_o !== 1'b0 || ld_hit_o !== 1'b0 || ld_data_o !== 16'h0) begin
      fails++; $display("FAIL areset_outputs: got v=%b c=%0d rdy=%b idx=%0d crdy=%b hit=%b d=%h", mem_v_o, count_o,
                        issue_ready_o, issue_idx_o, commit_ready_o, ld_hit_o, ld_data_o); end
    step();
    mem_ready_i = 1'b0;
    reset_n_i = 1'b1;
    step();
    tests_run++; if (mem_v_o !== 1'b0 || count_o !== 4'd0) begin fails++; $display("FAIL areset_after: got v=%b c=%0d want 0/0", mem_v_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_full_wrap();
    test_forward();
    test_flush_commit();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameters SHALL be: SQ_ENTRY, 8, queue depth (power of two, >=2); ADDR_W, 16, address width; DATA_W, 16, store data width; IDX_W, $clog2(SQ_ENTRY), entry index width.
REQ-002 clk_i  in  1  clock; all state updates on the rising edge.
REQ-003 reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 issue_v_i  in  1  allocate the tail entry this cycle.
REQ-005 issue_data_i  in  DATA_W  store data, known at issue.
REQ-006 issue_ready_o  out  1  at least one free entry and flush_i low.
REQ-007 issue_idx_o  out  IDX_W  index the next allocation will receive (tail).
REQ-008 exe_v_i / exe_idx_i / exe_addr_i  in  1 / IDX_W / ADDR_W  address writeback for entry exe_idx_i.
REQ-009 commit_v_i  in  1  ROB retires the oldest uncommitted store.
REQ-010 commit_ready_o  out  1  oldest uncommitted entry exists and has its address.
REQ-011 flush_i  in  1  mispredict; discard all uncommitted entries.
REQ-012 ld_addr_i  in  ADDR_W  load address to forward against.
REQ-013 ld_hit_o / ld_data_o  out  1 / DATA_W  forwarding hit and data (0 when no hit).
REQ-014 mem_v_o / mem_ready_i  out / in  1 / 1  drain handshake to memory.
REQ-015 mem_addr_o / mem_data_o  out  ADDR_W / DATA_W  head entry address and data.
REQ-016 count_o  out  IDX_W+1  number of occupied entries.

Function
REQ-017 Each entry SHALL hold one of four states: FREE, ALLOC (data only), RESOLVED (address written), COMMITTED.
REQ-018 Three pointers SHALL exist: head (drain), cmt (oldest uncommitted), tail (allocate). Each is IDX_W wide and wraps modulo SQ_ENTRY.
REQ-019 When issue_v_i && issue_ready_o, the queue SHALL: move entry[tail] FREE->ALLOC, store the data, and increment tail. issue_v_i while not ready SHALL be ignored.
REQ-020 When exe_v_i targets an ALLOC entry, the queue SHALL store the address and move the entry to RESOLVED. exe_v_i to any other state SHALL be ignored.
REQ-021 When commit_v_i && commit_ready_o, the queue SHALL move entry[cmt] RESOLVED->COMMITTED and increment cmt. commit_v_i without commit_ready_o SHALL be ignored.
REQ-022 mem_v_o SHALL be high iff entry[head] is COMMITTED (Moore, no dependence on mem_ready_i).
REQ-023 When mem_v_o && mem_ready_i, the queue SHALL free entry[head] and increment head. mem_addr_o and mem_data_o SHALL hold stable while mem_v_o is high and unaccepted.
REQ-024 On flush_i, the queue SHALL free all ALLOC/RESOLVED entries and set tail to cmt. COMMITTED entries and head SHALL be preserved.
REQ-025 Same-cycle precedence SHALL be: commit applied before flush (the committed entry survives); drain proceeds concurrently with flush; issue is suppressed by flush; exe writeback to a flushed entry is discarded.
REQ-026 Same-cycle issue and drain when full SHALL NOT allocate (issue_ready_o is computed from the registered count).
REQ-027 Forwarding SHALL be combinational. ld_hit_o asserts if any RESOLVED/COMMITTED entry address equals ld_addr_i. ld_data_o SHALL come from the youngest such entry, age ordered from tail-1 back to head.
REQ-028 Occupancy SHALL be derived as count_o = tail-head-equivalent entries. Full when count_o==SQ_ENTRY; empty when 0. The tail==head ambiguity SHALL be resolved by count, not by pointer compare.

Reset
REQ-029 While reset_n_i is low, the block SHALL asynchronously set: all entries FREE; head=cmt=tail=0; count_o=0.
REQ-030 Output values during reset SHALL be: issue_ready_o=1, issue_idx_o=0, commit_ready_o=0, mem_v_o=0, ld_hit_o=0, ld_data_o=0.
REQ-031 Reset asserted mid-drain SHALL drop mem_v_o immediately, with no completion owed.

Structure
REQ-032 The entry-state enum (FREE/ALLOC/RESOLVED/COMMITTED) and default constants SQ_ENTRY and WORD_SIZE_P SHALL live in Purple_Jade_pkg. The entry struct SHALL be local, since it is parameter-sized.
REQ-033 The age-ordered forwarding priority selector SHALL be one sub-module, store_queue_fwd, parameterised on SQ_ENTRY, ADDR_W and DATA_W.

Verification
REQ-034 Directed scenario: issue 0x1111, exe addr 0x0040, commit, mem_ready_i=1 -> mem_v_o high one cycle after commit, with addr 0x0040 and data 0x1111; count returns to 0.
REQ-035 Directed scenario: issue 8 stores with no drain -> issue_ready_o=0 and count_o=8; one drain -> issue_ready_o=1 next cycle; next allocation wraps to issue_idx_o=0.
REQ-036 Directed scenario: issue A (0xAAAA) then B (0xBBBB), both at addr 0x0010, plus C at 0x0020; ld_addr_i=0x0010 -> ld_hit_o=1, ld_data_o=0xBBBB.
REQ-037 Directed scenario: 2 committed + 3 uncommitted entries, flush_i with simultaneous commit_v_i -> 3 entries remain COMMITTED, tail=cmt, count_o=3.
REQ-038 Directed scenario: hold mem_ready_i=0 for 5 cycles with head committed -> mem_v_o stays high and address/data stay stable; the pop occurs in exactly the cycle mem_ready_i=1.
REQ-039 Directed scenario: assert reset_n_i low asynchronously mid-drain -> all outputs reach their reset values before the next clock edge.
